// File: rtl/tl_intersection_model.sv
// rtl/tl_intersection_model.sv - four-lane intersection queue model closing the loop around a traffic light controller
// Optional light-protocol monitor enabled by defining TL_CONFLICT_MON_EN.
module tl_intersection_model #(
    parameter int QW      = 4,
    parameter int DEP_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arr_a,
    input  logic          arr_al,
    input  logic          arr_b,
    input  logic          arr_bl,
    input  logic [1:0]    La,
    input  logic [1:0]    Lb,
    output logic          Ta,
    output logic          Tal,
    output logic          Tb,
    output logic          Tbl,
    output logic [QW-1:0] qa,
    output logic [QW-1:0] qal,
    output logic [QW-1:0] qb,
    output logic [QW-1:0] qbl,
    output logic [3:0]    dep,
    output logic          fault,
    output logic [1:0]    fault_code
);

    localparam logic [1:0]    L_GREEN  = 2'b00;
    localparam logic [1:0]    L_LEFT   = 2'b10;
    localparam logic [1:0]    L_RED    = 2'b11;
    localparam logic [QW-1:0] Q_MAX    = '1;
    localparam logic [QW-1:0] Q_ONE    = {{(QW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    T_LAST   = 4'(DEP_CYC - 1);

    logic [3:0]          arr;
    logic [3:0]          perm;
    logic [3:0]          depart;
    logic [3:0][QW-1:0]  cnt_q, cnt_d;
    logic [3:0][3:0]     timer_q, timer_d;
    logic [3:0]          dep_q;

    // Lane order {bl, b, al, a} matches the dep output.
    assign arr  = {arr_bl, arr_b, arr_al, arr_a};
    assign perm = {Lb == L_LEFT, Lb == L_GREEN, La == L_LEFT, La == L_GREEN};

    always_comb begin
        depart  = '0;
        timer_d = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (perm[i] && (cnt_q[i] != '0)) begin
                if (timer_q[i] == T_LAST) depart[i] = 1'b1;
                else                      timer_d[i] = timer_q[i] + 4'd1;
            end
            // A simultaneous arrival and departure leaves the count unchanged.
            if (arr[i] && !depart[i] && (cnt_q[i] != Q_MAX)) cnt_d[i] = cnt_q[i] + Q_ONE;
            else if (!arr[i] && depart[i])                    cnt_d[i] = cnt_q[i] - Q_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            timer_q <= '0;
            dep_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            dep_q   <= depart;
        end
    end

    assign qa  = cnt_q[0];
    assign qal = cnt_q[1];
    assign qb  = cnt_q[2];
    assign qbl = cnt_q[3];
    assign Ta  = |cnt_q[0];
    assign Tal = |cnt_q[1];
    assign Tb  = |cnt_q[2];
    assign Tbl = |cnt_q[3];
    assign dep = dep_q;

`ifdef TL_CONFLICT_MON_EN
    logic [1:0] prev_a_q, prev_b_q;
    logic       fault_q;
    logic [1:0] code_q;
    logic       conflict, skipped;
    logic [1:0] viol_code;

    always_comb begin
        conflict = (La != L_RED) && (Lb != L_RED);
        skipped  = (((prev_a_q == L_GREEN) || (prev_a_q == L_LEFT)) && (La == L_RED)) ||
                   (((prev_b_q == L_GREEN) || (prev_b_q == L_LEFT)) && (Lb == L_RED));
        viol_code = 2'b00;
        if (conflict)     viol_code = 2'b01;
        else if (skipped) viol_code = 2'b10;
    end

    // First violation wins; the code is held until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_a_q <= L_RED;
            prev_b_q <= L_RED;
            fault_q  <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            prev_a_q <= La;
            prev_b_q <= Lb;
            if (!fault_q && (viol_code != 2'b00)) begin
                fault_q <= 1'b1;
                code_q  <= viol_code;
            end
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
`else
    assign fault      = 1'b0;
    assign fault_code = 2'b00;
`endif

endmodule
